// File: rtl/ch3_wt_time_counter_pkg.sv
// Shared constants and helpers for the time-of-day counter and its display path.
package ch3_wt_pkg;

    // Field width shared with the tens/units digit separator.
    localparam int TIME_W = 7;

    localparam logic [TIME_W-1:0] SEC_MAX  = 7'd59;
    localparam logic [TIME_W-1:0] MIN_MAX  = 7'd59;
    localparam logic [TIME_W-1:0] HOUR_MAX = 7'd23;

    // Bit positions of the set-mode buttons in the packed button vector.
    localparam int BTN_HOUR = 0;
    localparam int BTN_MIN  = 1;
    localparam int BTN_SEC  = 2;
    localparam int BTN_NUM  = 3;

    // Modulo increment: wraps to zero after max, so a field can never leave 0..max.
    function automatic logic [TIME_W-1:0] wrap_inc(input logic [TIME_W-1:0] val,
                                                   input logic [TIME_W-1:0] max);
        if (val == max) begin
            return '0;
        end
        return val + 7'd1;
    endfunction

endpackage

// File: rtl/ch3_wt_time_counter_if.sv
// Control/status bundle between the time counter and its controller/display.
interface ch3_wt_time_counter_if;
    import ch3_wt_pkg::*;

    logic              RUN;
    logic              SET_MODE;
    logic              INC_HOUR;
    logic              INC_MIN;
    logic              CLR_SEC;
    logic [TIME_W-1:0] HOUR;
    logic [TIME_W-1:0] MIN;
    logic [TIME_W-1:0] SEC;
    logic              SEC_TICK;
    logic              DAY_WRAP;

    modport master (
        output RUN, SET_MODE, INC_HOUR, INC_MIN, CLR_SEC,
        input  HOUR, MIN, SEC, SEC_TICK, DAY_WRAP
    );

    modport slave (
        input  RUN, SET_MODE, INC_HOUR, INC_MIN, CLR_SEC,
        output HOUR, MIN, SEC, SEC_TICK, DAY_WRAP
    );

endinterface

// File: rtl/ch3_wt_edge_det.sv
// 1-bit rising-edge detector; the history register updates every cycle.
module ch3_wt_edge_det (
    input  logic CLK,
    input  logic RESETN,
    input  logic din,
    output logic rise
);

    logic prev_reg;

    // Previous sample of the (already debounced) button level.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            prev_reg <= 1'b0;
        end else begin
            prev_reg <= din;
        end
    end

    assign rise = din & ~prev_reg;

endmodule

// File: rtl/ch3_wt_time_counter.sv
// 24-hour time-of-day counter with 1 Hz prescaler and push-button set mode.
module ch3_wt_time_counter
    import ch3_wt_pkg::*;
#(
    parameter int TICK_DIV = 1000,
    parameter int CNT_W    = 10
) (
    input  logic                  CLK,
    input  logic                  RESETN,
    ch3_wt_time_counter_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [BTN_NUM-1:0] btn;
    logic [BTN_NUM-1:0] rise;

    logic [CNT_W-1:0]  cnt_reg,  cnt_next;
    logic [TIME_W-1:0] sec_reg,  sec_next;
    logic [TIME_W-1:0] min_reg,  min_next;
    logic [TIME_W-1:0] hour_reg, hour_next;
    logic              tick_reg, tick_next;
    logic              wrap_reg, wrap_next;

    assign btn[BTN_HOUR] = bus.INC_HOUR;
    assign btn[BTN_MIN]  = bus.INC_MIN;
    assign btn[BTN_SEC]  = bus.CLR_SEC;

    genvar gi;
    generate
        for (gi = 0; gi < BTN_NUM; gi++) begin : g_edge
            ch3_wt_edge_det u_edge (
                .CLK    (CLK),
                .RESETN (RESETN),
                .din    (btn[gi]),
                .rise   (rise[gi])
            );
        end
    endgenerate

    // Next-state: set mode takes priority and suppresses the tick; otherwise
    // the prescaler runs under RUN and a tick advances the seconds chain.
    always_comb begin
        cnt_next  = cnt_reg;
        sec_next  = sec_reg;
        min_next  = min_reg;
        hour_next = hour_reg;
        tick_next = 1'b0;
        wrap_next = 1'b0;
        if (bus.SET_MODE) begin
            if (rise[BTN_HOUR]) begin
                hour_next = wrap_inc(hour_reg, HOUR_MAX);
            end
            if (rise[BTN_MIN]) begin
                min_next = wrap_inc(min_reg, MIN_MAX);
            end
            if (rise[BTN_SEC]) begin
                sec_next = '0;
                cnt_next = '0;
            end
        end else if (bus.RUN) begin
            if (cnt_reg == CNT_LAST) begin
                cnt_next  = '0;
                tick_next = 1'b1;
                sec_next  = wrap_inc(sec_reg, SEC_MAX);
                if (sec_reg == SEC_MAX) begin
                    min_next = wrap_inc(min_reg, MIN_MAX);
                    if (min_reg == MIN_MAX) begin
                        hour_next = wrap_inc(hour_reg, HOUR_MAX);
                        wrap_next = (hour_reg == HOUR_MAX);
                    end
                end
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    // State register; pulses are registered alongside the fields they qualify.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            cnt_reg  <= '0;
            sec_reg  <= '0;
            min_reg  <= '0;
            hour_reg <= '0;
            tick_reg <= 1'b0;
            wrap_reg <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            sec_reg  <= sec_next;
            min_reg  <= min_next;
            hour_reg <= hour_next;
            tick_reg <= tick_next;
            wrap_reg <= wrap_next;
        end
    end

    assign bus.HOUR     = hour_reg;
    assign bus.MIN      = min_reg;
    assign bus.SEC      = sec_reg;
    assign bus.SEC_TICK = tick_reg;
    assign bus.DAY_WRAP = wrap_reg;

endmodule

// File: tb/tb_ch3_wt_time_counter.sv
// Scoreboard bench: stimulus queues expected tick snapshots, a monitor checks them.
module tb_ch3_wt_time_counter;
    import ch3_wt_pkg::*;

    logic CLK = 1'b0;
    logic RESETN;

    always #5 CLK = ~CLK;

    ch3_wt_time_counter_if bus ();

    ch3_wt_time_counter #(
        .TICK_DIV (4),
        .CNT_W    (2)
    ) dut (
        .CLK    (CLK),
        .RESETN (RESETN),
        .bus    (bus)
    );

    typedef struct {
        int h;
        int m;
        int s;
        int dw;
        int cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   r0;

    // Cycle stamp: counts rising edges so tick timing can be checked exactly.
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    // Monitor: every SEC_TICK/DAY_WRAP pulse must match the next queued entry.
    always @(negedge CLK) begin
        if (RESETN && (bus.SEC_TICK || bus.DAY_WRAP)) begin
            if (q.size() == 0) begin
                check("unexpected_pulse", {30'd0, bus.SEC_TICK, bus.DAY_WRAP}, 0);
            end else begin
                mon_e = q.pop_front();
                n_checks++;
                if (bus.SEC_TICK && int'(bus.HOUR) == mon_e.h && int'(bus.MIN) == mon_e.m &&
                    int'(bus.SEC) == mon_e.s && int'(bus.DAY_WRAP) == mon_e.dw &&
                    cyc == mon_e.cyc) begin
                    n_pass++;
                    $display("tick cyc=%0d %0d:%0d:%0d dw=%0d ok",
                             cyc, bus.HOUR, bus.MIN, bus.SEC, bus.DAY_WRAP);
                end else begin
                    $display("FAIL tick: got cyc=%0d %0d:%0d:%0d dw=%0d st=%0d, want cyc=%0d %0d:%0d:%0d dw=%0d st=1",
                             cyc, bus.HOUR, bus.MIN, bus.SEC, bus.DAY_WRAP, bus.SEC_TICK,
                             mon_e.cyc, mon_e.h, mon_e.m, mon_e.s, mon_e.dw);
                end
            end
        end
    end

    task automatic push(input int h, input int m, input int s, input int dw, input int c);
        exp_t e;
        e.h = h; e.m = m; e.s = s; e.dw = dw; e.cyc = c;
        q.push_back(e);
    endtask

    // All stimulus lands 1 time unit after a falling edge.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge CLK);
            #1;
        end
    endtask

    task automatic press(input int which);
        case (which)
            BTN_HOUR: bus.INC_HOUR = 1'b1;
            BTN_MIN:  bus.INC_MIN  = 1'b1;
            default:  bus.CLR_SEC  = 1'b1;
        endcase
        step(1);
        bus.INC_HOUR = 1'b0;
        bus.INC_MIN  = 1'b0;
        bus.CLR_SEC  = 1'b0;
        step(1);
    endtask

    task automatic drain(input string name, input int budget);
        int t = 0;
        while (q.size() != 0 && t < budget) begin
            step(1);
            t++;
        end
        check(name, q.size(), 0);
    endtask

    task automatic check_time(input string name, input int h, input int m, input int s);
        check({name, "_hour"}, int'(bus.HOUR), h);
        check({name, "_min"},  int'(bus.MIN),  m);
        check({name, "_sec"},  int'(bus.SEC),  s);
    endtask

    initial begin
        RESETN       = 1'b0;
        bus.RUN      = 1'b0;
        bus.SET_MODE = 1'b0;
        bus.INC_HOUR = 1'b0;
        bus.INC_MIN  = 1'b0;
        bus.CLR_SEC  = 1'b0;
        step(3);
        check_time("reset", 0, 0, 0);
        check("reset_sec_tick", int'(bus.SEC_TICK), 0);
        check("reset_day_wrap", int'(bus.DAY_WRAP), 0);

        // Free run for one minute: a tick every 4 cycles.
        bus.RUN = 1'b1;
        r0      = cyc;
        RESETN  = 1'b1;
        for (int k = 1; k <= 60; k++) push(0, k / 60, k % 60, 0, r0 + 4 * k);
        drain("minute_drain", 300);
        bus.RUN = 1'b0;
        check_time("minute", 0, 1, 0);

        // Set 23:59:00 and let the day wrap.
        bus.SET_MODE = 1'b1;
        press(BTN_SEC);
        repeat (23) press(BTN_HOUR);
        repeat (58) press(BTN_MIN);
        check_time("set_2359", 23, 59, 0);
        bus.SET_MODE = 1'b0;
        bus.RUN      = 1'b1;
        r0           = cyc;
        for (int k = 1; k <= 60; k++) begin
            if (k == 60) push(0, 0, 0, 1, r0 + 4 * k);
            else         push(23, 59, k, 0, r0 + 4 * k);
        end
        drain("daywrap_drain", 300);
        bus.RUN = 1'b0;
        check_time("daywrap", 0, 0, 0);

        // Minute wraps in set mode without carrying; RUN high but ticks suppressed.
        bus.SET_MODE = 1'b1;
        bus.RUN      = 1'b1;
        repeat (5)  press(BTN_HOUR);
        repeat (59) press(BTN_MIN);
        check_time("set_0559", 5, 59, 0);
        press(BTN_MIN);
        check_time("min_wrap", 5, 0, 0);

        // Leave set mode: first tick one full period later.
        bus.SET_MODE = 1'b0;
        r0           = cyc;
        push(5, 0, 1, 0, r0 + 4);
        drain("resume_drain", 20);

        // Clear seconds with the prescaler at 2: next tick is a full period away.
        step(2);
        bus.SET_MODE = 1'b1;
        press(BTN_SEC);
        check_time("clr_sec", 5, 0, 0);
        bus.SET_MODE = 1'b0;
        r0           = cyc;
        push(5, 0, 1, 0, r0 + 4);
        drain("clr_drain", 20);

        // Enter set mode on the would-be tick cycle: tick is dropped, fires on exit.
        step(3);
        bus.SET_MODE = 1'b1;
        step(4);
        bus.SET_MODE = 1'b0;
        r0           = cyc;
        push(5, 0, 2, 0, r0 + 1);
        drain("drop_drain", 20);

        // Button already held when set mode rises must not fire.
        bus.RUN      = 1'b0;
        bus.INC_HOUR = 1'b1;
        step(3);
        bus.SET_MODE = 1'b1;
        step(3);
        check("held_no_fire", int'(bus.HOUR), 5);
        bus.INC_HOUR = 1'b0;
        step(2);
        bus.INC_HOUR = 1'b1;
        step(1);
        check("repress_once", int'(bus.HOUR), 6);
        step(3);
        check("repress_held", int'(bus.HOUR), 6);
        bus.INC_HOUR = 1'b0;
        step(1);

        // Run up to 12:34:56 and reset asynchronously mid-second.
        repeat (6)  press(BTN_HOUR);
        repeat (34) press(BTN_MIN);
        press(BTN_SEC);
        check_time("set_1234", 12, 34, 0);
        bus.SET_MODE = 1'b0;
        bus.RUN      = 1'b1;
        r0           = cyc;
        for (int k = 1; k <= 56; k++) push(12, 34, k, 0, r0 + 4 * k);
        drain("to_123456_drain", 300);
        step(2);
        #2;
        RESETN = 1'b0;
        #1;
        check_time("async_rst", 0, 0, 0);
        check("async_rst_tick", int'(bus.SEC_TICK), 0);
        step(1);
        r0     = cyc;
        RESETN = 1'b1;
        push(0, 0, 1, 0, r0 + 4);
        drain("post_rst_drain", 20);
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ch3_wt_time_counter.md
Name: ch3_wt_time_counter

Overview:
- Free-running 24-hour time-of-day counter for the alarm-clock datapath.
- Divides the system clock into a 1 Hz tick and maintains hours, minutes and seconds.
- Includes a set mode driven by debounced push-buttons.
- Outputs are 7-bit binary values, each fed directly to a tens/units digit separator per field, then on to the 7-segment/LCD display path.
- Guarantees separator inputs never exceed 59 (hours never exceed 23).

Parameters:
- TICK_DIV, 1000, CLK cycles per second tick; must be at least 2.
- CNT_W, 10, prescaler width; must satisfy 2^CNT_W >= TICK_DIV.

Ports:
- CLK  input  1  system clock.
- RESETN  input  1  asynchronous active-low reset.
- RUN  input  1  level; 1 = time advances, 0 = paused (prescaler frozen).
- SET_MODE  input  1  level; 1 = set mode (tick suppressed, buttons active).
- INC_HOUR  input  1  debounced button level; rising edge increments hour in set mode.
- INC_MIN  input  1  debounced button level; rising edge increments minute in set mode.
- CLR_SEC  input  1  debounced button level; rising edge zeroes seconds in set mode.
- HOUR  output  7  current hour, 0..23.
- MIN  output  7  current minute, 0..59.
- SEC  output  7  current second, 0..59.
- SEC_TICK  output  1  one-cycle pulse, high in the cycle a newly advanced SEC value first appears.
- DAY_WRAP  output  1  one-cycle pulse, high in the cycle 23:59:59 becomes 00:00:00.

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low (RESETN), sampled on CLK rising edge otherwise.
  - RESETN low clears HOUR, MIN, SEC, SEC_TICK, DAY_WRAP, the prescaler and the edge-detector history to 0 immediately, independent of CLK.
  - Reset mid-count discards the partial second.
- Prescaler:
  - Counts 0..TICK_DIV-1 while RUN=1 and SET_MODE=0, otherwise holds.
  - When it is at TICK_DIV-1 and enabled, it returns to 0 and an internal tick fires.
- Counting on tick (registered, 1-cycle latency):
  - SEC increments; 59 wraps to 0 and carries to MIN.
  - MIN 59 wraps to 0 and carries to HOUR.
  - HOUR 23 wraps to 0.
  - DAY_WRAP is asserted in the same cycle as the 23:59:59 -> 00:00:00 update.
  - SEC_TICK is asserted in the same cycle SEC takes its new value.
- Button edge detection:
  - Each button uses a registered previous sample; edge = current & ~previous.
  - Edge history updates every cycle regardless of mode, so a button already held when SET_MODE rises does not fire.
- Set mode (SET_MODE=1):
  - Tick is suppressed and the prescaler is held at its current value.
  - INC_HOUR edge: HOUR+1 mod 24, no effect on other fields.
  - INC_MIN edge: MIN+1 mod 60, no carry to HOUR.
  - CLR_SEC edge: SEC=0 and prescaler=0, so the next second is a full period after leaving set mode.
  - Simultaneous edges all apply in the same cycle.
  - SEC_TICK and DAY_WRAP stay 0 in set mode.
- Outside set mode: button edges are ignored.
- Mode change on the same cycle a tick would fire: SET_MODE=1 wins and the tick is dropped (prescaler holds at TICK_DIV-1).
- RUN=0 and SET_MODE=0: all fields hold; no pulses.
- Field ranges are invariant by construction. Values outside 0..59 (0..23 for HOUR) are unreachable, so downstream error codes never trigger.

Decomposition:
- Shared package ch3_wt_pkg:
  - Constants SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23.
  - TIME_W=7, the field width shared with the digit separator.
- Sub-module ch3_wt_edge_det:
  - 1-bit rising-edge detector with async active-low reset.
  - Instantiated three times (INC_HOUR, INC_MIN, CLR_SEC).
- Counter wrap logic stays inline.

Test Plan (TICK_DIV=4 in simulation):
- Reset release with RUN=1 for 4*60 cycles -> SEC_TICK pulses every 4 cycles; SEC steps 0..59 then 0; MIN=1 after 240 cycles.
- Set mode: INC_HOUR x23, INC_MIN x59, clear SET_MODE, then wait for SEC=59 -> the next SEC_TICK coincides with DAY_WRAP; outputs become 00:00:00.
- SET_MODE=1, MIN=59, INC_MIN edge -> MIN=0, HOUR unchanged, no SEC_TICK/DAY_WRAP.
- SET_MODE=1 with prescaler at 2, CLR_SEC edge -> SEC=0; after SET_MODE=0, first SEC_TICK occurs exactly 4 cycles later.
- INC_HOUR held high before SET_MODE rises -> no increment; release and re-press -> HOUR+1 exactly once, in the cycle after the edge.
- RESETN asserted asynchronously mid-second at 12:34:56 -> all outputs 0 before the next CLK edge; counting restarts with a full 4-cycle period.
